cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Execute-stage consumer of the ALU's flag outputs: {N,Z,C,V} and the Zero signal.
- Holds the architectural NZCV flag register and evaluates ARM condition codes against it.
- Gates RegWrite, MemWrite and branch for the current instruction.
- Registers the gated controls into the M stage: 1-cycle pipeline with stall/flush.

Parameters:
- COND_W, 4, width of condition field.
- FLAG_W, 4, width of flag vector {N,Z,C,V}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- CondE  in  4  ARM condition field of instruction in E
- FlagWriteE  in  2  bit1 = update N,Z; bit0 = update C,V
- ALUFlags  in  4  {N,Z,C,V} from ALU this cycle
- ZeroE  in  1  ALU result == 0
- RegWriteE  in  1  ungated register write
- MemWriteE  in  1  ungated memory write
- BranchE  in  1  instruction is a branch
- ValidE  in  1  E holds a real instruction
- StallE  in  1  hold E/M register and flags
- FlushE  in  1  kill instruction in E
- CondExE  out  1  condition passed (combinational)
- Flags  out  4  current registered NZCV
- RegWriteM  out  1  gated, registered
- MemWriteM  out  1  gated, registered
- PCSrcM  out  1  branch taken, registered
- ValidM  out  1  registered valid

Behaviour:
- Reset (reset==0 at clk edge):
  - Flags=0000.
  - RegWriteM, MemWriteM, PCSrcM, ValidM = 0.
  - Reset overrides stall and flush.
  - An instruction in flight during reset is dropped; no flag update occurs.
- CondExE is combinational from CondE and registered Flags (state before the current instruction). Encodings:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (reserved, never executes)
- Qualifier: Go = ValidE & ~FlushE & CondExE.
- Flag update at clk edge when ~StallE & Go:
  - FlagWriteE[1] loads N,Z from ALUFlags.
  - FlagWriteE[0] loads C,V from ALUFlags.
  - Unselected bits hold.
- C convention: for subtract, C is the borrow as produced by the ALU (1 when a<b unsigned). The ARM condition table uses C as stored, with no inversion.
- E/M register update at clk edge:
  - StallE=1: all M outputs and Flags hold, even if FlushE=1. Stall has priority over flush.
  - StallE=0, FlushE=1 or ~ValidE: ValidM, RegWriteM, MemWriteM, PCSrcM all load 0.
  - Otherwise: ValidM=1, RegWriteM=RegWriteE&Go, MemWriteM=MemWriteE&Go, PCSrcM=BranchE&Go.
- Latency: E inputs appear on the M outputs 1 cycle later.
- Flags written by instruction i are visible to CondExE of instruction i+1 in the next cycle, with no bypass needed.
- A condition-failed instruction still advances: ValidM=1, all write enables 0, flags unchanged.
- ZeroE is unused unless COND_RV_BRANCH_EN is defined.

Optional Feature:
- Macro COND_RV_BRANCH_EN. When defined, add inputs:
  - RvBranchE (1 bit)
  - Funct3E (3 bits)
- While RvBranchE=1:
  - Taken is evaluated on same-cycle ALU outputs of the compare subtract, not on registered Flags:
    - 000 beq: ZeroE
    - 001 bne: ~ZeroE
    - 100 blt: N^V
    - 101 bge: ~(N^V)
    - 110 bltu: C
    - 111 bgeu: ~C
    - others: 0
  - PCSrcM = Taken & ValidE & ~FlushE.
  - CondE is ignored; the flag register does not update.
- Without the macro: ports absent, ZeroE unused, behaviour is exactly as above.

Decomposition:
- Shared package holds:
  - cond_e enum (EQ..AL, NV)
  - flag bit index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0
  - funct3 branch constants
- One sub-module, cond_check: purely combinational evaluation of (CondE, Flags) to CondExE, reused by verification as a reference model.

Test Plan:
- Reset:
  - Drive reset=0 with garbage inputs -> Flags=0000, all M outputs 0.
  - Release, issue ValidE=1 with CondE=1110, RegWriteE=1 -> RegWriteM=1 next cycle.
- Flag update then condition:
  - Cycle 1: FlagWriteE=11, ALUFlags=0100.
  - Cycle 2: CondE=0000, RegWriteE=1 -> RegWriteM=1.
  - Same sequence with CondE=0001 -> RegWriteM=0, ValidM=1.
- Partial flag write:
  - Flags=1111, FlagWriteE=10, ALUFlags=0000 -> Flags=0011.
  - Condition-failed instruction with FlagWriteE=11 -> Flags unchanged.
- Stall vs flush:
  - StallE=1, FlushE=1 -> M outputs and Flags hold.
  - Next cycle StallE=0, FlushE=1 -> all M outputs 0, Flags unchanged.
- Signed condition sweep: all 16 CondE values × all 16 Flags values -> CondExE matches table; 1111 always 0.
- COND_RV_BRANCH_EN:
  - bltu, Funct3E=110, ALUFlags C=1 (0x1 - 0x2) -> PCSrcM=1.
  - bgeu on same operands -> PCSrcM=0.
  - beq with ZeroE=1 -> PCSrcM=1; Flags unchanged.

Source files
------------

// File: rtl/cond_unit_pkg.sv
// cond_unit_pkg: shared types and constants for the condition unit slice.
// Holds the ARM condition-code enum, NZCV bit positions and the RISC-V
// branch funct3 encodings used when COND_RV_BRANCH_EN is defined.
package cond_unit_pkg;

    // ARM condition field encodings; NV (1111) is reserved and never executes
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned N_IDX = 3;
    localparam int unsigned Z_IDX = 2;
    localparam int unsigned C_IDX = 1;
    localparam int unsigned V_IDX = 0;

    // RISC-V conditional branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Branch decision from the same-cycle compare subtract. C is the ALU borrow
    // (1 when a < b unsigned), so bltu takes on C directly.
    function automatic logic rv_branch_taken(
        input logic [2:0] funct3,
        input logic       zero,
        input logic [3:0] alu_flags
    );
        logic w_lt;
        w_lt = alu_flags[N_IDX] ^ alu_flags[V_IDX];
        case (funct3)
            F3_BEQ:  return zero;
            F3_BNE:  return ~zero;
            F3_BLT:  return w_lt;
            F3_BGE:  return ~w_lt;
            F3_BLTU: return alu_flags[C_IDX];
            F3_BGEU: return ~alu_flags[C_IDX];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_unit_cond_check.sv
// cond_check: purely combinational ARM condition-code evaluation of
// CondE against a {N,Z,C,V} flag vector. C is used exactly as stored.
module cond_check #(
    parameter int unsigned COND_W = 4,
    parameter int unsigned FLAG_W = 4
) (
    input  logic [COND_W-1:0] CondE,
    input  logic [FLAG_W-1:0] Flags,
    output logic              CondExE
);
    import cond_unit_pkg::*;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_pass;

    assign w_n = Flags[N_IDX];
    assign w_z = Flags[Z_IDX];
    assign w_c = Flags[C_IDX];
    assign w_v = Flags[V_IDX];

    // Decode the condition field into a pass/fail decision
    always_comb begin
        w_pass = 1'b0;
        case (cond_e'(CondE))
            EQ:      w_pass = w_z;
            NE:      w_pass = ~w_z;
            CS:      w_pass = w_c;
            CC:      w_pass = ~w_c;
            MI:      w_pass = w_n;
            PL:      w_pass = ~w_n;
            VS:      w_pass = w_v;
            VC:      w_pass = ~w_v;
            HI:      w_pass = w_c & ~w_z;
            LS:      w_pass = ~w_c | w_z;
            GE:      w_pass = (w_n == w_v);
            LT:      w_pass = (w_n != w_v);
            GT:      w_pass = ~w_z & (w_n == w_v);
            LE:      w_pass = w_z | (w_n != w_v);
            AL:      w_pass = 1'b1;
            NV:      w_pass = 1'b0;
            default: w_pass = 1'b0;
        endcase
    end

    assign CondExE = w_pass;

endmodule

// File: rtl/cond_unit.sv
// cond_unit: execute-stage condition unit. Holds the architectural NZCV
// register, gates RegWrite/MemWrite/branch on the ARM condition, and
// registers the gated controls into the M stage (1 cycle, stall/flush).
// Optional macro COND_RV_BRANCH_EN adds RvBranchE/Funct3E for RISC-V
// compare-and-branch evaluated on same-cycle ALU flags and ZeroE.
module cond_unit #(
    parameter int unsigned COND_W = 4,
    parameter int unsigned FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COND_W-1:0] CondE,
    input  logic [1:0]        FlagWriteE,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic              ZeroE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              ValidE,
    input  logic              StallE,
    input  logic              FlushE,
`ifdef COND_RV_BRANCH_EN
    input  logic              RvBranchE,
    input  logic [2:0]        Funct3E,
`endif
    output logic              CondExE,
    output logic [FLAG_W-1:0] Flags,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              PCSrcM,
    output logic              ValidM
);
    import cond_unit_pkg::*;

    logic [FLAG_W-1:0] r_flags;
    logic              r_valid_m;
    logic              r_regwrite_m;
    logic              r_memwrite_m;
    logic              r_pcsrc_m;

    logic w_cond_pass;
    logic w_issue;
    logic w_go;
    logic w_flag_en;
    logic w_take;

    // Condition is evaluated against the flags as they stood before this instruction
    cond_check #(
        .COND_W (COND_W),
        .FLAG_W (FLAG_W)
    ) u_cond_check (
        .CondE   (CondE),
        .Flags   (r_flags),
        .CondExE (w_cond_pass)
    );

    assign CondExE = w_cond_pass;
    assign w_issue = ValidE & ~FlushE;

`ifdef COND_RV_BRANCH_EN
    logic w_rv_taken;

    // RISC-V branches bypass the ARM condition and never touch the flag register
    assign w_rv_taken = rv_branch_taken(Funct3E, ZeroE, ALUFlags);
    assign w_go       = w_issue & (RvBranchE | w_cond_pass);
    assign w_flag_en  = w_go & ~RvBranchE;
    assign w_take     = RvBranchE ? w_rv_taken : BranchE;
`else
    logic w_unused_zero;

    assign w_unused_zero = ZeroE;
    assign w_go          = w_issue & w_cond_pass;
    assign w_flag_en     = w_go;
    assign w_take        = BranchE;
`endif

    // Architectural NZCV register: N,Z and C,V are independently write-enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flags <= '0;
        end else if (!StallE && w_flag_en) begin
            if (FlagWriteE[1]) begin
                r_flags[N_IDX] <= ALUFlags[N_IDX];
                r_flags[Z_IDX] <= ALUFlags[Z_IDX];
            end
            if (FlagWriteE[0]) begin
                r_flags[C_IDX] <= ALUFlags[C_IDX];
                r_flags[V_IDX] <= ALUFlags[V_IDX];
            end
        end
    end

    // E/M pipeline register: stall holds (beats flush), flush/invalid bubbles
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_m    <= 1'b0;
            r_regwrite_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_pcsrc_m    <= 1'b0;
        end else if (StallE) begin
            r_valid_m    <= r_valid_m;
            r_regwrite_m <= r_regwrite_m;
            r_memwrite_m <= r_memwrite_m;
            r_pcsrc_m    <= r_pcsrc_m;
        end else if (FlushE || !ValidE) begin
            r_valid_m    <= 1'b0;
            r_regwrite_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_pcsrc_m    <= 1'b0;
        end else begin
            r_valid_m    <= 1'b1;
            r_regwrite_m <= RegWriteE & w_go;
            r_memwrite_m <= MemWriteE & w_go;
            r_pcsrc_m    <= w_take & w_go;
        end
    end

    assign Flags     = r_flags;
    assign ValidM    = r_valid_m;
    assign RegWriteM = r_regwrite_m;
    assign MemWriteM = r_memwrite_m;
    assign PCSrcM    = r_pcsrc_m;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: self-checking bench for cond_unit. Directed vector table,
// full condition sweep, and randomized traffic against a reference model.
// Exercises the RISC-V branch path when COND_RV_BRANCH_EN is defined.
module tb_cond_unit;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] CondE;
    logic [1:0] FlagWriteE;
    logic [3:0] ALUFlags;
    logic       ZeroE;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       BranchE;
    logic       ValidE;
    logic       StallE;
    logic       FlushE;
`ifdef COND_RV_BRANCH_EN
    logic       RvBranchE;
    logic [2:0] Funct3E;
`endif
    logic       CondExE;
    logic [3:0] Flags;
    logic       RegWriteM;
    logic       MemWriteM;
    logic       PCSrcM;
    logic       ValidM;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cond_unit #(
        .COND_W (4),
        .FLAG_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .CondE      (CondE),
        .FlagWriteE (FlagWriteE),
        .ALUFlags   (ALUFlags),
        .ZeroE      (ZeroE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .BranchE    (BranchE),
        .ValidE     (ValidE),
        .StallE     (StallE),
        .FlushE     (FlushE),
`ifdef COND_RV_BRANCH_EN
        .RvBranchE  (RvBranchE),
        .Funct3E    (Funct3E),
`endif
        .CondExE    (CondExE),
        .Flags      (Flags),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .PCSrcM     (PCSrcM),
        .ValidM     (ValidM)
    );

    typedef struct packed {
        logic       rst_n;
        logic [3:0] cond;
        logic [1:0] fw;
        logic [3:0] aluf;
        logic       rw;
        logic       mw;
        logic       br;
        logic       v;
        logic       st;
        logic       fl;
        logic       exp_cx;
        logic [3:0] exp_flags;
        logic       exp_vm;
        logic       exp_rwm;
        logic       exp_mwm;
        logic       exp_pcm;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    // ARM conditions come in pairs: even code = base predicate, odd code = its inverse
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        logic [2:0] grp;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        grp = c[3:1];
        case (grp)
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic drive(input vec_t t);
        reset      = t.rst_n;
        CondE      = t.cond;
        FlagWriteE = t.fw;
        ALUFlags   = t.aluf;
        RegWriteE  = t.rw;
        MemWriteE  = t.mw;
        BranchE    = t.br;
        ValidE     = t.v;
        StallE     = t.st;
        FlushE     = t.fl;
    endtask

    task automatic check_m(input string tag, input logic [3:0] ef, input logic evm,
                           input logic erw, input logic emw, input logic epc);
        chk({tag, "_flags"}, 32'(Flags), 32'(ef));
        chk({tag, "_ctl"}, 32'({ValidM, RegWriteM, MemWriteM, PCSrcM}),
            32'({evm, erw, emw, epc}));
    endtask

    logic [3:0] m_flags;
    logic       m_vm, m_rwm, m_mwm, m_pcm;
    logic       m_cx, m_go;
    logic [3:0] m_mask;

    initial begin
        reset = 1'b0; CondE = '0; FlagWriteE = '0; ALUFlags = '0; ZeroE = 1'b0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0; ValidE = 1'b0;
        StallE = 1'b0; FlushE = 1'b0;
`ifdef COND_RV_BRANCH_EN
        RvBranchE = 1'b0; Funct3E = '0;
`endif

        //          rst cond  fw     aluf  rw mw br v  st fl | cx flags  vm rwm mwm pcm
        tbl[0]  = '{L, 4'hE, 2'b11, 4'hF, H, H, H, H, H, L,  L, 4'h0, L, L, L, L};
        tbl[1]  = '{H, 4'hE, 2'b00, 4'h0, H, L, L, H, L, L,  H, 4'h0, H, H, L, L};
        tbl[2]  = '{H, 4'hE, 2'b11, 4'h4, L, L, L, H, L, L,  H, 4'h4, H, L, L, L};
        tbl[3]  = '{H, 4'h0, 2'b00, 4'h0, H, L, L, H, L, L,  H, 4'h4, H, H, L, L};
        tbl[4]  = '{H, 4'h1, 2'b00, 4'h0, H, H, L, H, L, L,  L, 4'h4, H, L, L, L};
        tbl[5]  = '{H, 4'hE, 2'b11, 4'hF, L, L, L, H, L, L,  H, 4'hF, H, L, L, L};
        tbl[6]  = '{H, 4'hE, 2'b10, 4'h0, L, L, L, H, L, L,  H, 4'h3, H, L, L, L};
        tbl[7]  = '{H, 4'h0, 2'b11, 4'hC, H, L, L, H, L, L,  L, 4'h3, H, L, L, L};
        tbl[8]  = '{H, 4'hE, 2'b00, 4'h0, H, H, H, H, L, L,  H, 4'h3, H, H, H, H};
        tbl[9]  = '{H, 4'hE, 2'b11, 4'h0, L, L, L, H, H, H,  H, 4'h3, H, H, H, H};
        tbl[10] = '{H, 4'hE, 2'b11, 4'h0, H, H, H, H, L, H,  H, 4'h3, L, L, L, L};
        tbl[11] = '{H, 4'hE, 2'b11, 4'h0, H, H, H, L, L, L,  H, 4'h3, L, L, L, L};
        tbl[12] = '{H, 4'hF, 2'b11, 4'h0, H, H, H, H, L, L,  L, 4'h3, H, L, L, L};
        tbl[13] = '{L, 4'hE, 2'b11, 4'hA, H, L, L, H, L, L,  L, 4'h0, L, L, L, L};

        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i]);
            #1;
            if (tbl[i].rst_n) chk($sformatf("tbl%0d_cx", i), 32'(CondExE), 32'(tbl[i].exp_cx));
            @(posedge clk); #1;
            check_m($sformatf("tbl%0d", i), tbl[i].exp_flags, tbl[i].exp_vm,
                    tbl[i].exp_rwm, tbl[i].exp_mwm, tbl[i].exp_pcm);
        end

        // Condition sweep over every flag value
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0;
        for (int f = 0; f < 16; f++) begin
            ValidE = 1'b1; CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = 4'(f);
            @(posedge clk); #1;
            chk("sweep_flags", 32'(Flags), 32'(f));
            ValidE = 1'b0;
            for (int c = 0; c < 16; c++) begin
                CondE = 4'(c);
                #1;
                chk($sformatf("sweep_c%0d_f%0d", c, f), 32'(CondExE),
                    32'(ref_cond(4'(c), 4'(f))));
            end
        end

        // Randomized traffic against the reference model
        reset = 1'b0; ValidE = 1'b0;
        @(posedge clk); #1;
        m_flags = '0; m_vm = 1'b0; m_rwm = 1'b0; m_mwm = 1'b0; m_pcm = 1'b0;
        for (int n = 0; n < 500; n++) begin
            reset      = ($urandom_range(0, 31) != 0);
            CondE      = 4'($urandom());
            FlagWriteE = 2'($urandom());
            ALUFlags   = 4'($urandom());
            ZeroE      = 1'($urandom());
            RegWriteE  = 1'($urandom());
            MemWriteE  = 1'($urandom());
            BranchE    = 1'($urandom());
            ValidE     = ($urandom_range(0, 4) != 0);
            StallE     = ($urandom_range(0, 5) == 0);
            FlushE     = ($urandom_range(0, 5) == 0);
            #1;
            m_cx = ref_cond(CondE, m_flags);
            chk("rnd_cx", 32'(CondExE), 32'(m_cx));
            if (!reset) begin
                m_flags = '0; m_vm = 1'b0; m_rwm = 1'b0; m_mwm = 1'b0; m_pcm = 1'b0;
            end else if (!StallE) begin
                m_go   = ValidE && !FlushE && m_cx;
                m_mask = {FlagWriteE[1], FlagWriteE[1], FlagWriteE[0], FlagWriteE[0]};
                if (m_go) m_flags = (m_flags & ~m_mask) | (ALUFlags & m_mask);
                m_vm  = ValidE && !FlushE;
                m_rwm = RegWriteE && m_go;
                m_mwm = MemWriteE && m_go;
                m_pcm = BranchE && m_go;
            end
            @(posedge clk); #1;
            check_m($sformatf("rnd%0d", n), m_flags, m_vm, m_rwm, m_mwm, m_pcm);
        end

`ifdef COND_RV_BRANCH_EN
        // RISC-V branches: decided on same-cycle ALU flags, flag register untouched
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidE = 1'b1;
        RegWriteE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0; ZeroE = 1'b0;
        CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = 4'h0; RvBranchE = 1'b0;
        @(posedge clk); #1;
        check_m("rv_setup", 4'h0, H, L, L, L);
        // 0x1 - 0x2: N=1 Z=0 C(borrow)=1 V=0; CondE=EQ would fail on flags 0000
        RvBranchE = 1'b1; BranchE = 1'b1; CondE = 4'h0; ALUFlags = 4'hA; Funct3E = 3'b110;
        @(posedge clk); #1;
        check_m("rv_bltu", 4'h0, H, L, L, H);
        Funct3E = 3'b111;
        @(posedge clk); #1;
        check_m("rv_bgeu", 4'h0, H, L, L, L);
        Funct3E = 3'b000; ZeroE = 1'b1; ALUFlags = 4'h4;
        @(posedge clk); #1;
        check_m("rv_beq", 4'h0, H, L, L, H);
        FlushE = 1'b1;
        @(posedge clk); #1;
        check_m("rv_beq_flush", 4'h0, L, L, L, L);
        FlushE = 1'b0; RvBranchE = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
